qif_neuron_scheduler: RTL

Time-multiplexes one shared QIF neuron update datapath across N_NEURONS virtual neurons. Stores each neuron's membrane potential and synaptic input locally. On every prescaler tick it runs one sweep: each neuron in index order is issued to the datapath, the block waits for completion, and the result is written back. Sits between the tt_um top level and the QIF update unit, and exposes spike pulses, a readout mux and error flags.

---
 rtl/qif_neuron_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/qif_neuron_scheduler.sv
// rtl/qif_neuron_scheduler.sv - time-multiplexed QIF neuron sweep scheduler
// One shared update datapath is walked across all neurons on each prescaler tick.
module qif_neuron_scheduler #(
   parameter int          N_NEURONS    = 4,
   parameter logic [23:0] TICK_DIV     = 24'd10_000_000,
   parameter logic [7:0]  V_INIT       = 8'd0,
   parameter logic [7:0]  DONE_TIMEOUT = 8'd16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         i_wr_en,
   input  logic [$clog2(N_NEURONS)-1:0] i_wr_idx,
   input  logic [7:0]                   i_wr_data,
   input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
   output logic [7:0]                   v_rd,
   output logic                         upd_start,
   output logic [$clog2(N_NEURONS)-1:0] upd_idx,
   output logic [7:0]                   upd_v,
   output logic [7:0]                   upd_i,
   input  logic                         upd_done,
   input  logic [7:0]                   upd_v_next,
   input  logic                         upd_spike,
   output logic [N_NEURONS-1:0]         spike_vec,
   output logic                         sweep_done,
   output logic                         busy,
   output logic                         overrun,
   output logic                         timeout_err
);
   localparam int IDX_W = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_FIN} state_t;

   state_t               state_q, state_d;
   logic [23:0]          pre_q;
   logic                 tick;
   logic [7:0]           wait_q;
   logic [7:0]           v_q [N_NEURONS];
   logic [7:0]           i_q [N_NEURONS];
   logic [IDX_W-1:0]     idx_q, idx_nx;
   logic [7:0]           op_v_q, op_i_q, v_next_q;
   logic                 spk_q, tmo_q, timed_out;
   logic [N_NEURONS-1:0] acc_q;
   logic                 overrun_q, timeout_q;

   assign tick      = ena && (pre_q == TICK_DIV - 24'd1);
   assign idx_nx    = idx_q + IDX_W'(1);
   assign timed_out = (state_q == S_WAIT) && !upd_done && (wait_q == DONE_TIMEOUT - 8'd1);

   always_comb begin
      state_d    = state_q;
      upd_start  = 1'b0;
      sweep_done = 1'b0;
      case (state_q)
         S_IDLE:  if (tick) state_d = S_ISSUE;
         S_ISSUE: begin
            upd_start = ena;
            state_d   = S_WAIT;
         end
         S_WAIT:  if (upd_done || timed_out) state_d = S_WB;
         S_WB:    state_d = (idx_q == LAST_IDX) ? S_FIN : S_ISSUE;
         S_FIN: begin
            sweep_done = ena;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         wait_q    <= '0;
         idx_q     <= '0;
         op_v_q    <= '0;
         op_i_q    <= '0;
         v_next_q  <= '0;
         spk_q     <= 1'b0;
         tmo_q     <= 1'b0;
         acc_q     <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         for (int n = 0; n < N_NEURONS; n++) begin
            v_q[n] <= V_INIT;
            i_q[n] <= 8'd0;
         end
      end else begin
         if (i_wr_en) i_q[i_wr_idx] <= i_wr_data;
         if (ena) begin
            state_q <= state_d;
            pre_q   <= tick ? 24'd0 : pre_q + 24'd1;
            if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
            // Operands are loaded on the edge entering ISSUE, so a same-cycle current write lands afterwards.
            case (state_q)
               S_IDLE: if (tick) begin
                  idx_q  <= '0;
                  op_v_q <= v_q[0];
                  op_i_q <= i_q[0];
               end
               S_ISSUE: wait_q <= '0;
               S_WAIT: begin
                  if (upd_done) begin
                     v_next_q <= upd_v_next;
                     spk_q    <= upd_spike;
                     tmo_q    <= 1'b0;
                  end else if (timed_out) begin
                     spk_q     <= 1'b0;
                     tmo_q     <= 1'b1;
                     timeout_q <= 1'b1;
                  end else begin
                     wait_q <= wait_q + 8'd1;
                  end
               end
               S_WB: begin
                  if (!tmo_q) v_q[idx_q] <= v_next_q;
                  if (spk_q) acc_q[idx_q] <= 1'b1;
                  if (idx_q != LAST_IDX) begin
                     idx_q  <= idx_nx;
                     op_v_q <= v_q[idx_nx];
                     op_i_q <= i_q[idx_nx];
                  end
               end
               S_FIN: acc_q <= '0;
               default: ;
            endcase
         end
      end
   end

   assign v_rd        = v_q[rd_idx];
   assign upd_idx     = idx_q;
   assign upd_v       = op_v_q;
   assign upd_i       = op_i_q;
   assign spike_vec   = sweep_done ? acc_q : '0;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

endmodule
